// File: rtl/spi_burst_pkg.sv
// Shared types and defaults for the SPI register-bus burst sequencer.
package spi_burst_pkg;
  localparam int SPI_ASZ  = 7;
  localparam int SPI_DSZ  = 32;
  localparam int HDR_BITS = SPI_ASZ + 1;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_DATA = 2'd1,
    S_DONE = 2'd2
  } spi_burst_state_t;
endpackage

// File: rtl/spi_bit_deser.sv
// MSB-first data-word deserializer with in-word bit counter; o_word includes
// the bit being sampled so the parent can capture it on the word-end edge.
module spi_bit_deser
  import spi_burst_pkg::*;
#(
  parameter int DSZ = SPI_DSZ
) (
  input  logic           spiclk,
  input  logic           spi_reset,
  input  logic           i_en,
  input  logic           i_bit,
  output logic [DSZ-1:0] o_word,
  output logic           o_word_end
);
  localparam int CW = $clog2(DSZ);

  logic [CW-1:0]  r_cnt;
  logic [DSZ-2:0] r_sh;

  always_ff @(posedge spiclk or posedge spi_reset) begin
    if (spi_reset) begin
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (i_en) begin
      r_sh  <= {r_sh[DSZ-3:0], i_bit};
      r_cnt <= o_word_end ? '0 : r_cnt + CW'(1);
    end
  end

  assign o_word     = {r_sh, i_bit};
  assign o_word_end = i_en && (r_cnt == CW'(DSZ - 1));
endmodule

// File: rtl/spi_burst_ctrl.sv
// SPI burst sequencer: header parse, per-word read-prefetch/write strobes.
// Address auto-increment is enabled by defining SPI_BURST_AUTOINC_EN.
module spi_burst_ctrl
  import spi_burst_pkg::*;
#(
  parameter int ASZ       = SPI_ASZ,
  parameter int DSZ       = SPI_DSZ,
  parameter int MAX_WORDS = 16
) (
  input  logic           spiclk,
  input  logic           spi_reset,
  input  logic           spimosi,
  output logic           rd,
  output logic [ASZ-1:0] addr,
  output logic           re,
  output logic [ASZ-1:0] waddr,
  output logic [DSZ-1:0] wdat,
  output logic           we,
  output logic [7:0]     word_cnt,
  output logic           busy,
  output logic           ovf
);
  localparam int HCW = $clog2(ASZ + 1);

  spi_burst_state_t r_state, w_state_nxt;
  logic [HCW-1:0] r_hcnt;
  logic [ASZ-2:0] r_hsh;
  logic           r_rd, r_re, r_we, r_busy, r_ovf;
  logic [ASZ-1:0] r_addr, r_waddr;
  logic [DSZ-1:0] r_wdat;
  logic [7:0]     r_word_cnt;

  logic [DSZ-1:0] w_word;
  logic           w_word_end, w_hdr_end, w_word_done, w_last, w_more;
  logic [7:0]     w_cnt_nxt;

  spi_bit_deser #(.DSZ(DSZ)) u_deser (
    .spiclk     (spiclk),
    .spi_reset  (spi_reset),
    .i_en       (r_state == S_DATA),
    .i_bit      (spimosi),
    .o_word     (w_word),
    .o_word_end (w_word_end)
  );

  assign w_cnt_nxt = r_word_cnt + 8'd1;
  assign w_last    = (w_cnt_nxt == 8'(MAX_WORDS));
  assign w_more    = (w_cnt_nxt <  8'(MAX_WORDS));

  always_ff @(posedge spiclk or posedge spi_reset) begin
    if (spi_reset) r_state <= S_HDR;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hdr_end   = 1'b0;
    w_word_done = 1'b0;
    case (r_state)
      S_HDR:  if (r_hcnt == HCW'(ASZ)) begin
                w_hdr_end   = 1'b1;
                w_state_nxt = S_DATA;
              end
      S_DATA: if (w_word_end) begin
                w_word_done = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
              end
      default: ;
    endcase
  end

  always_ff @(posedge spiclk or posedge spi_reset) begin
    if (spi_reset) begin
      r_hcnt     <= '0;
      r_hsh      <= '0;
      r_rd       <= 1'b0;
      r_re       <= 1'b0;
      r_we       <= 1'b0;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
      r_addr     <= '0;
      r_waddr    <= '0;
      r_wdat     <= '0;
      r_word_cnt <= '0;
    end else begin
      r_re   <= 1'b0;
      r_we   <= 1'b0;
      r_busy <= 1'b1;
      if (r_state == S_HDR) begin
        r_hcnt <= r_hcnt + HCW'(1);
        if (r_hcnt == '0) r_rd  <= spimosi;
        else              r_hsh <= {r_hsh[ASZ-3:0], spimosi};
      end
      if (w_hdr_end) begin
        r_addr <= {r_hsh, spimosi};
        r_re   <= r_rd;
      end
      if (w_word_done) begin
        r_wdat     <= w_word;
        r_waddr    <= r_addr;
        r_we       <= ~r_rd;
        r_word_cnt <= w_cnt_nxt;
        // the final word's prefetch would read past the burst, so suppress it
        r_re       <= r_rd && w_more;
`ifdef SPI_BURST_AUTOINC_EN
        r_addr     <= r_addr + ASZ'(1);
`else
        r_addr     <= r_addr;
`endif
      end
      if (r_state == S_DONE) r_ovf <= 1'b1;
    end
  end

  assign rd       = r_rd;
  assign addr     = r_addr;
  assign re       = r_re;
  assign waddr    = r_waddr;
  assign wdat     = r_wdat;
  assign we       = r_we;
  assign word_cnt = r_word_cnt;
  assign busy     = r_busy;
  assign ovf      = r_ovf;
endmodule

// File: doc/spi_burst_ctrl.md
# spi_burst_ctrl

Burst sequencer for the SPI register-bus slave interface, running entirely in the spiclk domain. It parses the read/write header, then sequences an unbounded-by-protocol stream of data words into per-word read-prefetch and write strobes. Addresses auto-increment per word, so a single chip-select window can access a contiguous register range. It sits between the SPI pins and the register file; the MISO load/shift path consumes `re`/`addr`, and the system-clock write synchronizer consumes `we`/`waddr`/`wdat`.

## Interface
Parameters:
- `ASZ`, 7: address width.
- `DSZ`, 32: data word width.
- `MAX_WORDS`, 16: maximum words per burst (1..255).

Ports:
- `spiclk`  in  1: SPI clock; data sampled on rising edge.
- `spi_reset`  in  1: asynchronous, active-high reset; system reset OR'd with `spicsl`, so it is also the end-of-transfer.
- `spimosi`  in  1: serial data, MSB first.
- `rd`  out  1: direction flag latched from header bit 0 (1 = read).
- `addr`  out  ASZ: current read address; valid whenever `re`=1.
- `re`  out  1: one-spiclk read-prefetch pulse.
- `waddr`  out  ASZ: address of the last completed write word.
- `wdat`  out  DSZ: last completed write word.
- `we`  out  1: one-spiclk write pulse; `waddr`/`wdat` are stable from this pulse until the next `we`.
- `word_cnt`  out  8: completed data words in this burst.
- `busy`  out  1: high from the first rising edge until reset.
- `ovf`  out  1: sticky; a bit was received after `MAX_WORDS` words completed.

## Operation
- FSM states:
  - `S_HDR`: reset state; receives bits 0..ASZ.
  - `S_DATA`: receives data words.
  - `S_DONE`: burst limit reached; incoming bits are ignored.
- `S_HDR`:
  - Bit 0 is loaded into `rd`.
  - Bits 1..ASZ are the address, MSB first.
  - On bit ASZ: `addr` is loaded with the assembled address, `re` is set to `rd`, and the FSM enters `S_DATA` with the in-word counter at 0.
- `S_DATA`:
  - Each bit shifts into a DSZ-bit register.
  - On in-word bit DSZ-1 (word end):
    - `wdat` <= the assembled word; `waddr` <= `addr`; `we` <= ~`rd`.
    - `addr` <= `addr`+1.
    - `word_cnt` <= `word_cnt`+1.
    - `re` <= `rd` AND (`word_cnt`+1 < MAX_WORDS).
  - If `word_cnt`+1 == MAX_WORDS, the FSM goes to `S_DONE`.
- `S_DONE`: any rising edge sets `ovf`; no strobes are generated.
- Address arithmetic: modulo 2^ASZ; all-ones wraps to 0 with no flag.
- Read bursts: `we` never pulses. Write bursts: `re` never pulses.
- Reset mid-word: the partial word is discarded. No strobe is generated, and no strobe is generated on reset release.

## Timing
- Reset values: all outputs 0; FSM in `S_HDR`; counters 0.
- All outputs are registered on rising spiclk. `re` and `we` are exactly one spiclk period wide.
- The first `re` is asserted on the edge sampling header bit ASZ (the 8th edge for ASZ=7). The consumer's falling edge loads `rdat` from `addr`.
- Subsequent `re` pulses coincide with the word-end edge. `addr` has already advanced on that same edge.
- `we` is asserted on the edge sampling the last bit of each word. For word k (0-based) that is edge ASZ+1+DSZ·(k+1); edge 40 for the first word at defaults.
- Simultaneous events at the final word end: `we` pulses, the FSM enters `S_DONE`, and `re` stays low. `ovf` rises only on the following edge.

## Configuration
- `SPI_BURST_AUTOINC_EN` defined: `addr` increments at each word end, as described above.
- `SPI_BURST_AUTOINC_EN` undefined: `addr` holds the header address for the whole burst (FIFO-port mode). In this mode `waddr` equals the header address for every word; all other behaviour is unchanged.

## Structure
- Package `spi_burst_pkg`:
  - state encoding: `S_HDR`, `S_DATA`, `S_DONE`.
  - `HDR_BITS` = ASZ+1.
  - default ASZ/DSZ constants shared with the register file.
- Sub-module `spi_bit_deser`: a DSZ-bit MSB-first shift register plus an in-word bit counter with a `word_end` output. Reset is `spi_reset`, clock is `spiclk`. The FSM, address and strobe logic stay in the top level.

## Test plan
- Write burst, header 0x05, words 0xDEADBEEF and 0x12345678:
  - `we` pulses at edges 40 and 72.
  - `waddr`/`wdat` are 0x05/0xDEADBEEF, then 0x06/0x12345678; `re` never pulses.
- Read burst, header 0x80|0x10, 3 words: `re` pulses at edges 8, 40 and 72 with `addr` 0x10, 0x11 and 0x12; `we` stays 0.
- Wrap: read burst at 0x7F, 2 words: second `re` has `addr`=0x00.
- Limit: MAX_WORDS=2 write, 3 words clocked:
  - `we` pulses exactly twice; `word_cnt`=2.
  - `ovf`=1 after edge 73; no third `we`.
- `spi_reset` asserted at edge 20 of word 0:
  - no `we` pulse; all outputs return to 0 asynchronously.
  - a new burst after release behaves normally.
- Build without `SPI_BURST_AUTOINC_EN`: 3-word write at 0x22 gives `waddr`=0x22 on all three `we` pulses.
